// File: rtl/neuron_pkg.sv
// Shared types, default sizes and arithmetic helpers
// for the neuron MAC array.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        QUANT,
        DONE
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_LEN_W  = 16;
    localparam int DEF_N_THR  = 15;

    // Signed add clamped to a w-bit two's complement range
    // (w < 64); the result is sign-extended to 64 bits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (s > hi) begin
            return 64'(hi);
        end else if (s < lo) begin
            return 64'(lo);
        end
        return 64'(s);
    endfunction

endpackage

// File: rtl/neuron_mac_array_lane_mul.sv
// One signed multiply lane of the neuron MAC array.
// Ports: a, b (DATA_W signed) -> p (2*DATA_W signed product).
module neuron_lane_mul #(
    parameter int DATA_W = 8
) (
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/neuron_mac_array.sv
// Dot-product neuron: LANES-wide MAC with saturating accumulator,
// then a serial threshold scan that quantizes the sum to a count.
// Ports: sys_clk, sys_rst_n (async, active-low);
//   activ_in/weight_in + in_valid/in_ready/in_length: beat input;
//   thr_wr/thr_addr/thr_data: threshold writes (IDLE only);
//   out/out_valid/out_ready: quantized result handshake.
module neuron_mac_array
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int N_THR  = DEF_N_THR,
    localparam int OUT_W  = $clog2(N_THR + 1),
    localparam int THR_AW = (N_THR > 1) ? $clog2(N_THR) : 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [LANES*DATA_W-1:0] activ_in,
    input  logic [LANES*DATA_W-1:0] weight_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LEN_W-1:0]        in_length,
    input  logic                    thr_wr,
    input  logic [THR_AW-1:0]       thr_addr,
    input  logic [ACC_W-1:0]        thr_data,
    output logic [OUT_W-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int SUM_W = 2 * DATA_W + $clog2(LANES);
    localparam logic [THR_AW-1:0] IDX_LAST = THR_AW'(N_THR - 1);

    state_t state_q;
    state_t state_d;

    logic signed [2*DATA_W-1:0] prod_c [LANES];
    logic signed [2*DATA_W-1:0] prod_q [LANES];
    logic                       s1_valid_q;
    logic                       s1_last_q;
    logic signed [SUM_W-1:0]    beat_sum;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_sel;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic              last_beat;
    logic              fire;
    logic              ready_d;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] thr_q [N_THR];
    logic [THR_AW-1:0]       idx_q;
    logic [OUT_W-1:0]        cnt_q;
    logic [OUT_W-1:0]        cnt_inc;
    logic                    thr_we;
    logic                    release_out;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        neuron_lane_mul #(
            .DATA_W (DATA_W)
        ) u_mul (
            .a (activ_in[i*DATA_W +: DATA_W]),
            .b (weight_in[i*DATA_W +: DATA_W]),
            .p (prod_c[i])
        );
    end

    // The tree reads the registered products, so the beat sum is
    // valid in the same cycle as the registered last flag.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + SUM_W'(prod_q[i]);
        end
    end

    assign fire = in_valid && in_ready;

    // in_length is only live on the first beat; later beats use
    // the copy captured then. A length of 0 means one beat.
    always_comb begin
        len_sel = (state_q == IDLE) ? in_length : len_q;
        if (len_sel == '0) begin
            len_sel = LEN_W'(1);
        end
        last_beat = ({1'b0, beat_cnt_q} + 1'b1) >= {1'b0, len_sel};
    end

    assign acc_sum = ACC_W'(sat_add(64'(acc_q), 64'(beat_sum), ACC_W));
    assign cnt_inc = cnt_q + OUT_W'(acc_q >= thr_q[idx_q]);
    assign thr_we  = thr_wr && (state_q == IDLE)
                     && (int'(thr_addr) < N_THR);
    assign release_out = (state_q == DONE) && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fire) state_d = ACCUM;
            ACCUM:   if (s1_valid_q && s1_last_q) state_d = QUANT;
            QUANT:   if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accepting the last beat closes the input until the result
    // has been taken.
    assign ready_d = ((state_d == IDLE) || (state_d == ACCUM))
                     && !(fire && last_beat);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            in_ready   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            len_q      <= '0;
            beat_cnt_q <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            for (int i = 0; i < N_THR; i++) begin
                thr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_ready   <= ready_d;
            s1_valid_q <= fire;

            if (fire) begin
                prod_q     <= prod_c;
                s1_last_q  <= last_beat;
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
                if (state_q == IDLE) begin
                    len_q <= in_length;
                end
            end

            if (release_out) begin
                acc_q <= '0;
            end else if (s1_valid_q) begin
                acc_q <= acc_sum;
            end

            // Index and count sit at 0 outside QUANT, so every
            // scan starts fresh.
            if (state_q == QUANT) begin
                cnt_q <= cnt_inc;
                idx_q <= idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    out       <= cnt_inc;
                    out_valid <= 1'b1;
                end
            end else begin
                cnt_q <= '0;
                idx_q <= '0;
            end

            if (release_out) begin
                out       <= '0;
                out_valid <= 1'b0;
            end

            if (thr_we) begin
                thr_q[thr_addr] <= thr_data;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_array.sv
// Directed and randomized checks of neuron_mac_array against a
// plain-arithmetic dot-product / threshold-count model.
module tb_neuron_mac_array;

    localparam int DW  = 8;
    localparam int LN  = 4;
    localparam int AW  = 16;
    localparam int LW  = 16;
    localparam int NT  = 3;
    localparam int OW  = 2;
    localparam int TAW = 2;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic [LN*DW-1:0]     activ_in = '0;
    logic [LN*DW-1:0]     weight_in = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [LW-1:0]        in_length = '0;
    logic                 thr_wr = 1'b0;
    logic [TAW-1:0]       thr_addr = '0;
    logic [AW-1:0]        thr_data = '0;
    logic [OW-1:0]        out;
    logic                 out_valid;
    logic                 out_ready = 1'b1;

    neuron_mac_array #(
        .DATA_W (DW),
        .LANES  (LN),
        .ACC_W  (AW),
        .LEN_W  (LW),
        .N_THR  (NT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .activ_in  (activ_in),
        .weight_in (weight_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_length (in_length),
        .thr_wr    (thr_wr),
        .thr_addr  (thr_addr),
        .thr_data  (thr_data),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [31:0] va [16];
    logic [31:0] vw [16];
    int thr_m [NT];

    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int s16(input int v);
        logic signed [15:0] x;
        x = 16'(v);
        return int'(x);
    endfunction

    // Dot product of nb beats with per-beat saturation to AW bits,
    // then the number of thresholds the sum reaches.
    function automatic int model(input int nb);
        longint acc = 0;
        int c = 0;
        for (int b = 0; b < nb; b++) begin
            longint s = 0;
            for (int i = 0; i < LN; i++) begin
                byte a;
                byte w;
                a = va[b][i*8 +: 8];
                w = vw[b][i*8 +: 8];
                s += longint'(a) * longint'(w);
            end
            acc += s;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
        end
        for (int i = 0; i < NT; i++) begin
            if (acc >= longint'(thr_m[i])) c++;
        end
        return c;
    endfunction

    task automatic wr(input int a, input int d);
        @(negedge sys_clk);
        thr_wr = 1'b1;
        thr_addr = TAW'(a);
        thr_data = AW'(d);
        @(negedge sys_clk);
        thr_wr = 1'b0;
    endtask

    task automatic set_thr(input int t0, input int t1, input int t2);
        wr(0, t0);
        wr(1, t1);
        wr(2, t2);
        thr_m[0] = s16(t0);
        thr_m[1] = s16(t1);
        thr_m[2] = s16(t2);
    endtask

    task automatic fill(input int nb, input logic [31:0] a,
                        input logic [31:0] w);
        for (int b = 0; b < nb; b++) begin
            va[b] = a;
            vw[b] = w;
        end
    endtask

    // Returns 1 once the beat has been accepted at a rising edge.
    task automatic send_beat(input string tag, input int b,
                             input int len, output bit ok);
        int k = 0;
        @(negedge sys_clk);
        in_valid = 1'b1;
        activ_in = va[b];
        weight_in = vw[b];
        in_length = LW'(len);
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        ok = (in_ready === 1'b1);
        if (!ok) begin
            chk({tag, "_accept"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_vector(input string tag, input int len,
                              input int nb, input bit gaps,
                              input bit inj, input bit hold);
        int exp_out;
        int tl;
        int tv = -1;
        bit ok;
        logic [OW-1:0] held;
        exp_out = model(nb);
        if (hold) out_ready = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (gaps && b > 0 && $urandom_range(0, 1) == 1) begin
                @(negedge sys_clk);
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge sys_clk);
            end
            send_beat(tag, b, len, ok);
            if (!ok) return;
        end
        tl = cyc;
        @(negedge sys_clk);
        in_valid = 1'b0;
        chk({tag, "_ready_drop"}, in_ready, 0);
        if (inj) begin
            @(negedge sys_clk);
            thr_wr = 1'b1;
            thr_addr = 2'd0;
            thr_data = 16'h7fff;
            @(negedge sys_clk);
            thr_wr = 1'b0;
        end
        for (int k = 0; k < 60; k++) begin
            if (out_valid === 1'b1) begin
                tv = cyc;
                break;
            end
            @(negedge sys_clk);
        end
        chk({tag, "_valid"}, (tv >= 0), 1);
        if (tv < 0) return;
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_latency"}, tv - tl, NT + 1);
        if (hold) begin
            held = out;
            repeat (5) begin
                @(negedge sys_clk);
                chk({tag, "_hold_out"}, out, held);
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge sys_clk);
        chk({tag, "_release_valid"}, out_valid, 0);
        chk({tag, "_release_out"}, out, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        bit ok;
        int seen;

        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_release_ready", in_ready, 1);

        set_thr(0, 10, 20);
        fill(2, 32'h01010101, 32'h02020202);
        chk("basic_model", model(2), 2);
        run_vector("basic", 2, 2, 1'b0, 1'b0, 1'b0);

        set_thr(32767, 0, -5);
        fill(2, 32'h80808080, 32'h80808080);
        run_vector("saturate", 2, 2, 1'b0, 1'b0, 1'b0);

        set_thr(-4, -3, 0);
        fill(1, 32'h01010101, 32'hffffffff);
        run_vector("len0", 0, 1, 1'b0, 1'b0, 1'b0);

        wr(3, -30000);
        fill(1, 32'h01010101, 32'h00000000);
        run_vector("drop_wr", 1, 1, 1'b0, 1'b1, 1'b0);
        fill(1, 32'h01010101, 32'hffffffff);
        run_vector("drop_after", 1, 1, 1'b0, 1'b0, 1'b0);

        fill(3, 32'h05fb0302, 32'h01020304);
        run_vector("hold", 3, 3, 1'b0, 1'b0, 1'b1);

        set_thr(100, 200, 300);
        fill(1, 32'h01010101, 32'h01010101);
        in_length = LW'(3);
        send_beat("rst_mid", 0, 3, ok);
        @(negedge sys_clk);
        in_valid = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", in_ready, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_out", out, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_mid_ready_up", in_ready, 1);
        seen = 0;
        repeat (12) begin
            @(negedge sys_clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk("rst_mid_no_out", seen, 0);
        thr_m[0] = 0;
        thr_m[1] = 0;
        thr_m[2] = 0;
        fill(2, 32'h01010101, 32'h01010101);
        run_vector("post_rst", 2, 2, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            int nb;
            int len;
            nb = $urandom_range(1, 4);
            len = (nb == 1) ? $urandom_range(0, 1) : nb;
            set_thr(int'($urandom()), int'($urandom()), int'($urandom()));
            for (int b = 0; b < nb; b++) begin
                va[b] = $urandom();
                vw[b] = $urandom();
                if (r < 5) begin
                    va[b] = va[b] & 32'h1f1f1f1f;
                    thr_m[0] = thr_m[0];
                end
            end
            if (r < 5) begin
                set_thr($urandom_range(0, 4000) - 2000,
                        $urandom_range(0, 4000) - 2000,
                        $urandom_range(0, 4000) - 2000);
            end
            run_vector($sformatf("rand%0d", r), len, nb, 1'b1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac_array.md
NEURON_MAC_ARRAY -- requirements
Module: neuron_mac_array

Interface
REQ-001 Parameter DATA_W, default 8: signed activation/weight width.
REQ-002 Parameter LANES, default 4: parallel multiply lanes per beat.
REQ-003 Parameter ACC_W, default 32: signed accumulator width.
REQ-004 Parameter LEN_W, default 16: beat-count width.
REQ-005 Parameter N_THR, default 15: threshold count; OUT_W = clog2(N_THR+1).
REQ-006 Port sys_clk  in  1: clock, rising edge.
REQ-007 Port sys_rst_n  in  1: reset, asynchronous, active-low.
REQ-008 Port activ_in  in  LANES*DATA_W: signed activations, lane i at bits [i*DATA_W +: DATA_W].
REQ-009 Port weight_in  in  LANES*DATA_W: signed weights, same packing.
REQ-010 Port in_valid / in_ready  in / out  1 each: input beat handshake; a beat transfers when both are high.
REQ-011 Port in_length  in  LEN_W: beats per dot product, sampled on the first beat of each vector.
REQ-012 Port thr_wr, thr_addr, thr_data  in  1, clog2(N_THR), ACC_W: threshold register write.
REQ-013 Port out, out_valid / out_ready  out OUT_W, out 1 / in 1: quantized result and output handshake.

Function
REQ-014 The module SHALL use states IDLE, ACCUM, QUANT and DONE; in_ready SHALL be high only in IDLE and ACCUM.
REQ-015 Each transferred beat SHALL register the LANES signed products, their adder-tree sum and a last flag one edge after transfer.
REQ-016 The beat counter SHALL flag last when count+1 >= in_length; in_length 0 SHALL be treated as 1.
REQ-017 The first beat SHALL move IDLE to ACCUM; transfer of the last beat SHALL drop in_ready on the following cycle.
REQ-018 The accumulator SHALL add each registered beat sum, with saturation to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping.
REQ-019 One edge after the registered last-beat sum is added, state SHALL go to QUANT with compare index 0 and count 0.
REQ-020 QUANT SHALL compare one threshold per cycle and increment the count when sum >= thr[idx] (signed) over idx 0..N_THR-1.
REQ-021 On the edge evaluating idx N_THR-1, out SHALL take the final count, out_valid SHALL rise and state SHALL go to DONE; thresholds need not be sorted.
REQ-022 Latency SHALL be exactly N_THR+1 edges from last-beat transfer to out_valid high, with out_ready held high.
REQ-023 In DONE, out and out_valid SHALL hold until out_ready is high; on that edge out_valid SHALL fall, the accumulator SHALL clear and state SHALL go to IDLE.
REQ-024 Gaps with in_valid low during ACCUM SHALL preserve the accumulator and beat count.
REQ-025 A thr_wr SHALL be applied only in IDLE; writes in any other state, or with thr_addr >= N_THR, SHALL be dropped.
REQ-026 out SHALL be 0 whenever out_valid is low.

Reset
REQ-027 Asserting sys_rst_n low SHALL immediately force state IDLE, out 0, out_valid 0, in_ready 0, accumulator 0, counters 0 and all thresholds 0.
REQ-028 The first edge after deassertion SHALL raise in_ready; an in-flight vector interrupted by reset SHALL be discarded with no output.

Structure
REQ-029 Package neuron_pkg SHALL hold the state enum, default parameter constants and the saturating-add function.
REQ-030 Sub-module neuron_lane_mul SHALL implement one signed DATA_W x DATA_W -> 2*DATA_W multiplier, instantiated LANES times.

Verification (LANES=4, N_THR=3 unless stated)
REQ-031 Thresholds {0,10,20}; in_length 2; all activ 1, weight 2 -> sum 16, out 2, out_valid high 4 edges after the last beat.
REQ-032 ACC_W=16; in_length 2; all activ -128, weight -128 -> accumulator saturates to 32767; thresholds {32767,0,-5} -> out 3.
REQ-033 in_length 0 with one beat of activ 1, weight -1 (sum -4); thresholds {-4,-3,0} -> out 1 after a single beat.
REQ-034 out_ready low for 5 cycles after out_valid -> out stable, in_ready low, then IDLE one edge after out_ready rises.
REQ-035 sys_rst_n pulsed low mid-ACCUM -> out_valid never rises for that vector, thresholds read back 0, and the next vector computes correctly.
REQ-036 thr_wr issued in QUANT and with thr_addr 3 -> both dropped; the result uses the prior threshold values.
